iq_push_sequencer: RTL and testbench
====================================

Name: iq_push_sequencer

Overview:
- Producer side of the instruction queue push interface. Accepts one decoded loop instruction at a time from the decoder via a valid/ready handshake.
- Splits the instruction's total copy count into superscalar groups of at most 16 copies and advances base addresses between groups.
- Drives the queue's push port, honouring stall_push.
- Owns the queue flush when the queue signals needs_reset.

Parameters:
- LOG_SUPERSCALAR_WIDTH, 4, log2 of maximum copies per pushed group.
- SUPERSCALAR_WIDTH, 16, maximum copies per group; equals 2**LOG_SUPERSCALAR_WIDTH.
- COUNT_BITS, 16, width of the total loop copy count.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoder offers an instruction.
- in_ready  out  1  sequencer accepts an instruction this cycle.
- in_instr_type  in  2  INSTR_TYPE_RAM / INSTR_TYPE_LOAD_STORE / INSTR_TYPE_ARITHMETIC.
- in_count  in  COUNT_BITS  total copies; 0 means no-op.
- in_cache_addr, in_d_cache_addr  in  11 each  base cache address and per-copy stride.
- in_main_mem_addr, in_d_main_mem_addr  in  7 each  base main memory address and per-copy stride.
- in_arith_instr  in  9  arithmetic payload.
- in_ram_instr  in  3  DMA payload.
- in_ld_st_instr  in  7  load/store payload.
- iq_we  out  1  push strobe.
- iq_instr_type  out  2  pushed type.
- iq_copy_count  out  LOG_SUPERSCALAR_WIDTH+1  copies in this group, 1..16.
- iq_cache_addr, iq_d_cache_addr  out  11 each  group base and stride.
- iq_main_mem_addr, iq_d_main_mem_addr  out  7 each  group base and stride.
- iq_arith_instr / iq_ram_instr / iq_ld_st_instr  out  9 / 3 / 7  payload, held for the whole instruction.
- iq_stall_push  in  1  queue cannot accept a push.
- iq_needs_reset  in  1  queue read position saturated.
- iq_empty  in  1  queue drained.
- iq_flush  out  1  one-cycle synchronous reset pulse to the queue.
- busy  out  1  state != IDLE.

Behaviour:
- Reset asserted, which is asynchronous:
  - State = IDLE.
  - remaining = 0.
  - All iq_* data registers = 0.
  - iq_flush = 0.
  - resume = 0.
- Reset takes effect mid-instruction, discarding the remaining groups. No partial group is pushed after reset release.
- FSM states: IDLE, ISSUE, DRAIN, FLUSH.
- in_ready = (state==IDLE) & !iq_needs_reset.
- Handshake: a transfer occurs on in_valid & in_ready.
- On a transfer with in_count==0: the instruction is consumed and the state stays IDLE. No push.
- On a transfer with in_count!=0:
  - Register type, payload, strides and bases.
  - Set remaining = in_count.
  - Go to ISSUE. The first iq_we is possible the cycle after acceptance (1-cycle latency).
- ISSUE, combinational strobe and group size:
  - iq_we = (state==ISSUE) & !iq_stall_push & !iq_needs_reset.
  - iq_copy_count = min(remaining, 16), registered with the other data outputs.
- On each cycle with iq_we:
  - remaining -= iq_copy_count.
  - iq_cache_addr += iq_d_cache_addr<<4, mod 2^11.
  - iq_main_mem_addr += iq_d_main_mem_addr<<4, mod 2^7.
  - If remaining reaches 0, go to IDLE. Outputs hold their last values; only iq_we qualifies them.
- iq_stall_push high: hold all registers, no push, no state change. There is no limit on stall length.
- iq_needs_reset seen in IDLE or ISSUE: latch resume = (state==ISSUE), then go to DRAIN. Pushes stop the same cycle.
- iq_needs_reset and in_valid in the same IDLE cycle: no transfer.
- DRAIN: wait until iq_empty==1, then go to FLUSH.
- FLUSH: iq_flush=1 for exactly one cycle. Next state is ISSUE if resume, else IDLE. remaining and addresses are unchanged, so the flush loses no group.
- iq_needs_reset must be low the cycle after iq_flush. It is ignored during FLUSH and for the following cycle.
- Example group splits: in_count=16 gives one group of 16. in_count=17 gives groups 16, 1. in_count=0xFFFF gives 4095 groups of 16, then 15.

Decomposition:
- Shared package:
  - INSTR_TYPE_RAM / LOAD_STORE / ARITHMETIC encodings.
  - SUPERSCALAR_WIDTH and LOG_SUPERSCALAR_WIDTH, shared with the instruction queue.
  - The FSM state enum.
- Natural sub-module: iq_group_splitter. It holds remaining and the address accumulators, and produces copy_count plus next bases on an advance strobe.

Test Plan:
- in_count=5, cache 100, d 3, no stall -> one iq_we, cycle after accept; copy_count 5, cache_addr 100; busy drops the next cycle.
- in_count=40, cache 10, d 2, mm 1, dmm 1 -> three pushes: (16, 10, 1), (16, 42, 17), (8, 74, 33).
- in_count=20, iq_stall_push high for 3 cycles after the first push -> the second push occurs exactly after the stall releases, with copy_count 4 and no duplicate.
- Cache base 2040, d 1, count 32 -> second group cache_addr = 8 (wrap mod 2048).
- iq_needs_reset rises mid-instruction, iq_empty rises 2 cycles later -> DRAIN for 2 cycles, one-cycle iq_flush, then the remaining groups resume with unchanged addresses. A zero-count instruction is consumed with no push.
- Reset asserted during ISSUE with remaining=30 -> no iq_we after release; in_ready=1 and outputs are 0.

Source files
------------

// File: rtl/iq_push_sequencer_pkg.sv
// Shared definitions for the instruction-queue push sequencer and the queue.
package iq_push_sequencer_pkg;

  localparam int unsigned LOG_SUPERSCALAR_WIDTH = 4;
  localparam int unsigned SUPERSCALAR_WIDTH     = 2 ** LOG_SUPERSCALAR_WIDTH;
  localparam int unsigned COUNT_BITS            = 16;
  localparam int unsigned CC_W                  = LOG_SUPERSCALAR_WIDTH + 1;
  localparam int unsigned TYPE_W                = 2;
  localparam int unsigned CACHE_AW              = 11;
  localparam int unsigned MM_AW                 = 7;
  localparam int unsigned ARITH_W               = 9;
  localparam int unsigned RAM_W                 = 3;
  localparam int unsigned LDST_W                = 7;

  localparam logic [TYPE_W-1:0] INSTR_TYPE_RAM        = 2'd0;
  localparam logic [TYPE_W-1:0] INSTR_TYPE_LOAD_STORE = 2'd1;
  localparam logic [TYPE_W-1:0] INSTR_TYPE_ARITHMETIC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Per-instruction payload, held unchanged across all of its groups.
  typedef struct packed {
    logic [ARITH_W-1:0] arith;
    logic [RAM_W-1:0]   ram;
    logic [LDST_W-1:0]  ld_st;
  } payload_t;

  // Copies in the next group: min(remaining, SUPERSCALAR_WIDTH).
  function automatic logic [CC_W-1:0] group_size(input logic [COUNT_BITS-1:0] rem);
    if (rem >= COUNT_BITS'(SUPERSCALAR_WIDTH)) return CC_W'(SUPERSCALAR_WIDTH);
    else                                       return CC_W'(rem);
  endfunction

endpackage

// File: rtl/iq_group_splitter.sv
// Splits a total copy count into groups of at most SUPERSCALAR_WIDTH and
// advances the cache / main-memory bases by one full group stride per push.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_load                capture a new instruction (count, bases, strides)
//   i_advance             a group was pushed this cycle
//   i_count               total copies of the new instruction
//   i_*_addr / i_d_*      bases and per-copy strides of the new instruction
//   o_copy_count          size of the current group
//   o_*_addr / o_d_*      current group base and stride
//   o_last_c              current group is the final one
module iq_group_splitter
  import iq_push_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_advance,
  input  logic [COUNT_BITS-1:0] i_count,
  input  logic [CACHE_AW-1:0]   i_cache_addr,
  input  logic [CACHE_AW-1:0]   i_d_cache_addr,
  input  logic [MM_AW-1:0]      i_main_mem_addr,
  input  logic [MM_AW-1:0]      i_d_main_mem_addr,
  output logic [CC_W-1:0]       o_copy_count,
  output logic [CACHE_AW-1:0]   o_cache_addr,
  output logic [CACHE_AW-1:0]   o_d_cache_addr,
  output logic [MM_AW-1:0]      o_main_mem_addr,
  output logic [MM_AW-1:0]      o_d_main_mem_addr,
  output logic                  o_last_c
);

  logic [COUNT_BITS-1:0] r_remaining;
  logic [COUNT_BITS-1:0] w_rem_next;

  assign w_rem_next = r_remaining - COUNT_BITS'(o_copy_count);
  assign o_last_c   = (w_rem_next == '0);

  // Group size is kept registered alongside the bases so all push data is
  // valid from the first cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining       <= '0;
      o_copy_count      <= '0;
      o_cache_addr      <= '0;
      o_d_cache_addr    <= '0;
      o_main_mem_addr   <= '0;
      o_d_main_mem_addr <= '0;
    end else if (i_load) begin
      r_remaining       <= i_count;
      o_copy_count      <= group_size(i_count);
      o_cache_addr      <= i_cache_addr;
      o_d_cache_addr    <= i_d_cache_addr;
      o_main_mem_addr   <= i_main_mem_addr;
      o_d_main_mem_addr <= i_d_main_mem_addr;
    end else if (i_advance) begin
      r_remaining     <= w_rem_next;
      o_copy_count    <= group_size(w_rem_next);
      // Bases wrap naturally at the address width.
      o_cache_addr    <= o_cache_addr + (o_d_cache_addr << LOG_SUPERSCALAR_WIDTH);
      o_main_mem_addr <= o_main_mem_addr + (o_d_main_mem_addr << LOG_SUPERSCALAR_WIDTH);
    end
  end

endmodule

// File: rtl/iq_push_sequencer.sv
// Producer side of the instruction-queue push port: accepts one decoded loop
// instruction, pushes it as superscalar groups, and owns the queue flush.
// Ports:
//   clk, reset                clock, async active-low reset
//   in_valid/in_ready         decoder handshake
//   in_*                      decoded instruction fields
//   iq_we, iq_*               queue push strobe and group data
//   iq_stall_push             queue cannot accept a push
//   iq_needs_reset, iq_empty  queue flush request / drained status
//   iq_flush                  one-cycle queue reset pulse
//   busy                      sequencer not idle
module iq_push_sequencer
  import iq_push_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TYPE_W-1:0]     in_instr_type,
  input  logic [COUNT_BITS-1:0] in_count,
  input  logic [CACHE_AW-1:0]   in_cache_addr,
  input  logic [CACHE_AW-1:0]   in_d_cache_addr,
  input  logic [MM_AW-1:0]      in_main_mem_addr,
  input  logic [MM_AW-1:0]      in_d_main_mem_addr,
  input  logic [ARITH_W-1:0]    in_arith_instr,
  input  logic [RAM_W-1:0]      in_ram_instr,
  input  logic [LDST_W-1:0]     in_ld_st_instr,
  output logic                  iq_we,
  output logic [TYPE_W-1:0]     iq_instr_type,
  output logic [CC_W-1:0]       iq_copy_count,
  output logic [CACHE_AW-1:0]   iq_cache_addr,
  output logic [CACHE_AW-1:0]   iq_d_cache_addr,
  output logic [MM_AW-1:0]      iq_main_mem_addr,
  output logic [MM_AW-1:0]      iq_d_main_mem_addr,
  output logic [ARITH_W-1:0]    iq_arith_instr,
  output logic [RAM_W-1:0]      iq_ram_instr,
  output logic [LDST_W-1:0]     iq_ld_st_instr,
  input  logic                  iq_stall_push,
  input  logic                  iq_needs_reset,
  input  logic                  iq_empty,
  output logic                  iq_flush,
  output logic                  busy
);

  state_e   r_state;
  state_e   w_state_nxt;
  logic     r_resume;
  logic     w_resume_nxt;
  logic     r_nr_mask;
  logic     w_nr;
  logic     w_load;
  logic     w_last;
  logic     r_type_unused;
  payload_t r_payload;
  logic [TYPE_W-1:0] r_type;

  // needs_reset is ignored for the cycle following a flush.
  assign w_nr = iq_needs_reset & ~r_nr_mask;

  // State register plus flush bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_resume  <= 1'b0;
      r_nr_mask <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_resume  <= w_resume_nxt;
      r_nr_mask <= (r_state == ST_FLUSH);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_resume_nxt = r_resume;
    case (r_state)
      ST_IDLE: begin
        if (w_nr) begin
          w_state_nxt  = ST_DRAIN;
          w_resume_nxt = 1'b0;
        end else if (in_valid && (in_count != '0)) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_nr) begin
          w_state_nxt  = ST_DRAIN;
          w_resume_nxt = 1'b1;
        end else if (!iq_stall_push && w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (iq_empty) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_state_nxt = r_resume ? ST_ISSUE : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    in_ready = 1'b0;
    iq_we    = 1'b0;
    iq_flush = 1'b0;
    busy     = 1'b0;
    w_load   = 1'b0;
    in_ready = (r_state == ST_IDLE) && !w_nr;
    iq_we    = (r_state == ST_ISSUE) && !iq_stall_push && !w_nr;
    iq_flush = (r_state == ST_FLUSH);
    busy     = (r_state != ST_IDLE);
    // Zero-count instructions are consumed without loading anything.
    w_load   = in_valid && in_ready && (in_count != '0);
  end

  // Type and payload held for the whole instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_type    <= '0;
      r_payload <= '0;
    end else if (w_load) begin
      r_type    <= in_instr_type;
      r_payload <= '{arith: in_arith_instr, ram: in_ram_instr, ld_st: in_ld_st_instr};
    end
  end

  assign r_type_unused  = 1'b0;
  assign iq_instr_type  = r_type;
  assign iq_arith_instr = r_payload.arith;
  assign iq_ram_instr   = r_payload.ram;
  assign iq_ld_st_instr = r_payload.ld_st;

  iq_group_splitter u_splitter (
    .clk               (clk),
    .rst_n             (reset),
    .i_load            (w_load),
    .i_advance         (iq_we),
    .i_count           (in_count),
    .i_cache_addr      (in_cache_addr),
    .i_d_cache_addr    (in_d_cache_addr),
    .i_main_mem_addr   (in_main_mem_addr),
    .i_d_main_mem_addr (in_d_main_mem_addr),
    .o_copy_count      (iq_copy_count),
    .o_cache_addr      (iq_cache_addr),
    .o_d_cache_addr    (iq_d_cache_addr),
    .o_main_mem_addr   (iq_main_mem_addr),
    .o_d_main_mem_addr (iq_d_main_mem_addr),
    .o_last_c          (w_last)
  );

endmodule

// File: tb/tb_iq_push_sequencer.sv
// Directed self-checking bench for iq_push_sequencer.
module tb_iq_push_sequencer;
  import iq_push_sequencer_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [TYPE_W-1:0]     in_instr_type;
  logic [COUNT_BITS-1:0] in_count;
  logic [CACHE_AW-1:0]   in_cache_addr, in_d_cache_addr;
  logic [MM_AW-1:0]      in_main_mem_addr, in_d_main_mem_addr;
  logic [ARITH_W-1:0]    in_arith_instr;
  logic [RAM_W-1:0]      in_ram_instr;
  logic [LDST_W-1:0]     in_ld_st_instr;
  logic                  iq_we;
  logic [TYPE_W-1:0]     iq_instr_type;
  logic [CC_W-1:0]       iq_copy_count;
  logic [CACHE_AW-1:0]   iq_cache_addr, iq_d_cache_addr;
  logic [MM_AW-1:0]      iq_main_mem_addr, iq_d_main_mem_addr;
  logic [ARITH_W-1:0]    iq_arith_instr;
  logic [RAM_W-1:0]      iq_ram_instr;
  logic [LDST_W-1:0]     iq_ld_st_instr;
  logic                  iq_stall_push, iq_needs_reset, iq_empty, iq_flush, busy;

  int n_cmp = 0;
  int n_err = 0;

  iq_push_sequencer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr_type(in_instr_type),
    .in_count(in_count), .in_cache_addr(in_cache_addr), .in_d_cache_addr(in_d_cache_addr),
    .in_main_mem_addr(in_main_mem_addr), .in_d_main_mem_addr(in_d_main_mem_addr),
    .in_arith_instr(in_arith_instr), .in_ram_instr(in_ram_instr), .in_ld_st_instr(in_ld_st_instr),
    .iq_we(iq_we), .iq_instr_type(iq_instr_type), .iq_copy_count(iq_copy_count),
    .iq_cache_addr(iq_cache_addr), .iq_d_cache_addr(iq_d_cache_addr),
    .iq_main_mem_addr(iq_main_mem_addr), .iq_d_main_mem_addr(iq_d_main_mem_addr),
    .iq_arith_instr(iq_arith_instr), .iq_ram_instr(iq_ram_instr), .iq_ld_st_instr(iq_ld_st_instr),
    .iq_stall_push(iq_stall_push), .iq_needs_reset(iq_needs_reset), .iq_empty(iq_empty),
    .iq_flush(iq_flush), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction, confirm it is accepted, then withdraw it.
  task automatic offer(input string tag, input int cnt, input int ca, input int dca,
                       input int ma, input int dma);
    in_valid           = 1'b1;
    in_count           = COUNT_BITS'(cnt);
    in_cache_addr      = CACHE_AW'(ca);
    in_d_cache_addr    = CACHE_AW'(dca);
    in_main_mem_addr   = MM_AW'(ma);
    in_d_main_mem_addr = MM_AW'(dma);
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  // Expect a push this cycle with the given group data.
  task automatic expect_push(input string tag, input int cc, input int ca, input int ma);
    #1;
    chk({tag, ".we"},    32'(iq_we), 32'd1);
    chk({tag, ".cc"},    32'(iq_copy_count), 32'(cc));
    chk({tag, ".cache"}, 32'(iq_cache_addr), 32'(ca));
    chk({tag, ".mm"},    32'(iq_main_mem_addr), 32'(ma));
    cyc();
  endtask

  // Expect the sequencer back in IDLE with no push.
  task automatic expect_idle(input string tag);
    #1;
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".we"},   32'(iq_we), 32'd0);
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_instr_type = INSTR_TYPE_ARITHMETIC; in_count = '0;
    in_cache_addr = '0; in_d_cache_addr = '0; in_main_mem_addr = '0; in_d_main_mem_addr = '0;
    in_arith_instr = 9'h1A5; in_ram_instr = 3'd5; in_ld_st_instr = 7'h33;
    iq_stall_push = 1'b0; iq_needs_reset = 1'b0; iq_empty = 1'b0;
    #2 reset = 1'b0;
    cyc(); cyc();

    // Reset state
    chk("rst.busy",  32'(busy), 32'd0);
    chk("rst.we",    32'(iq_we), 32'd0);
    chk("rst.flush", 32'(iq_flush), 32'd0);
    chk("rst.cc",    32'(iq_copy_count), 32'd0);
    chk("rst.cache", 32'(iq_cache_addr), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    cyc();

    // Single small group, pushed the cycle after acceptance
    offer("t1", 5, 100, 3, 0, 0);
    expect_push("t1.p0", 5, 100, 0);
    expect_idle("t1.end");

    // Three groups with address advance; payload and type held
    offer("t2", 40, 10, 2, 1, 1);
    #1;
    chk("t2.type",  32'(iq_instr_type), 32'(INSTR_TYPE_ARITHMETIC));
    chk("t2.arith", 32'(iq_arith_instr), 32'h1A5);
    chk("t2.ldst",  32'(iq_ld_st_instr), 32'h33);
    expect_push("t2.p0", 16, 10, 1);
    expect_push("t2.p1", 16, 42, 17);
    expect_push("t2.p2", 8, 74, 33);
    expect_idle("t2.end");

    // Stall for three cycles between groups
    offer("t3", 20, 0, 1, 0, 0);
    expect_push("t3.p0", 16, 0, 0);
    iq_stall_push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3.stall.we",   32'(iq_we), 32'd0);
      chk("t3.stall.cc",   32'(iq_copy_count), 32'd4);
      chk("t3.stall.busy", 32'(busy), 32'd1);
      cyc();
    end
    iq_stall_push = 1'b0;
    expect_push("t3.p1", 4, 16, 0);
    expect_idle("t3.end");

    // Cache base wraps modulo 2048
    offer("t4", 32, 2040, 1, 0, 0);
    expect_push("t4.p0", 16, 2040, 0);
    expect_push("t4.p1", 16, 8, 0);
    expect_idle("t4.end");

    // Flush mid-instruction, then resume with unchanged addresses
    offer("t5", 40, 0, 1, 0, 1);
    expect_push("t5.p0", 16, 0, 0);
    iq_needs_reset = 1'b1;
    #1;
    chk("t5.nr.we",    32'(iq_we), 32'd0);
    chk("t5.nr.ready", 32'(in_ready), 32'd0);
    cyc();
    #1;
    chk("t5.drain0.busy",  32'(busy), 32'd1);
    chk("t5.drain0.flush", 32'(iq_flush), 32'd0);
    chk("t5.drain0.we",    32'(iq_we), 32'd0);
    cyc();
    iq_empty = 1'b1;
    #1;
    chk("t5.drain1.flush", 32'(iq_flush), 32'd0);
    cyc();
    iq_empty = 1'b0;
    #1;
    chk("t5.flush",    32'(iq_flush), 32'd1);
    chk("t5.flush.we", 32'(iq_we), 32'd0);
    cyc();
    iq_needs_reset = 1'b0;
    #1;
    chk("t5.post.flush", 32'(iq_flush), 32'd0);
    expect_push("t5.p1", 16, 16, 16);
    expect_push("t5.p2", 8, 32, 32);
    expect_idle("t5.end");

    // Zero-count instruction consumed with no push
    offer("t6", 0, 7, 1, 0, 0);
    expect_idle("t6.end");

    // needs_reset and in_valid together in IDLE: no transfer, flush, back to IDLE
    iq_needs_reset = 1'b1;
    in_valid = 1'b1; in_count = 16'd3;
    #1;
    chk("t7.ready", 32'(in_ready), 32'd0);
    cyc();
    in_valid = 1'b0;
    iq_empty = 1'b1;
    #1;
    chk("t7.drain.busy", 32'(busy), 32'd1);
    cyc();
    iq_empty = 1'b0;
    #1;
    chk("t7.flush", 32'(iq_flush), 32'd1);
    cyc();
    iq_needs_reset = 1'b0;
    #1;
    chk("t7.post.flush", 32'(iq_flush), 32'd0);
    expect_idle("t7.end");

    // Reset during ISSUE with 30 copies outstanding
    offer("t8", 30, 500, 1, 3, 1);
    iq_stall_push = 1'b1;
    #1;
    chk("t8.issue.cc", 32'(iq_copy_count), 32'd16);
    reset = 1'b0;
    #1;
    chk("t8.rst.busy",  32'(busy), 32'd0);
    chk("t8.rst.we",    32'(iq_we), 32'd0);
    chk("t8.rst.cc",    32'(iq_copy_count), 32'd0);
    chk("t8.rst.cache", 32'(iq_cache_addr), 32'd0);
    chk("t8.rst.mm",    32'(iq_main_mem_addr), 32'd0);
    cyc();
    reset = 1'b1;
    iq_stall_push = 1'b0;
    #1;
    chk("t8.rel.we",    32'(iq_we), 32'd0);
    chk("t8.rel.ready", 32'(in_ready), 32'd1);
    chk("t8.rel.cc",    32'(iq_copy_count), 32'd0);
    cyc();
    expect_idle("t8.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
